// File: rtl/hypipe_pkt_meta_merge.sv
// Tail-of-pipeline merge: pairs each buffered packet with its late-arriving metadata,
// optionally rewrites the Ethernet MACs on the head beat, and streams it out or discards it.
`timescale 1ns/1ps
module hypipe_pkt_meta_merge #(
  parameter int PKT_AW    = 9,
  parameter int META_AW   = 4,
  parameter int META_W    = 128,
  parameter int MAX_BEATS = 96
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pkt_valid,
  input  logic [133:0]      i_pkt,
  input  logic              i_meta_valid,
  input  logic [META_W-1:0] i_meta,
  input  logic [1:0]        i_mode,
  input  logic              i_out_ready,
  output logic              o_data_valid,
  output logic [133:0]      o_data,
  output logic [31:0]       o_pkt_cnt,
  output logic [31:0]       o_drop_cnt,
  output logic              o_meta_ovf
);

  localparam int PKT_DEPTH    = 1 << PKT_AW;
  localparam int META_DEPTH   = 1 << META_AW;
  localparam int META_ENTRY_W = 49;
  localparam logic [PKT_AW:0] ADMIT_MAX_USED = (PKT_AW+1)'(PKT_DEPTH - MAX_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_SEND, S_DROP} state_t;

  // ---------------- packet ingress and admission ----------------
  logic              in_head, in_tail;
  logic [PKT_AW:0]   pkt_wr_ptr_q, pkt_wr_ptr_d;
  logic [PKT_AW:0]   pkt_rd_ptr_q, pkt_rd_ptr_d;
  logic [PKT_AW:0]   pkt_used;
  logic              pkt_empty, pkt_full, admit_ok;
  logic              accepting_q, accepting_d;
  logic              pkt_wr_en, adm_drop;

  assign in_head   = i_pkt[132];
  assign in_tail   = i_pkt[133];
  assign pkt_used  = pkt_wr_ptr_q - pkt_rd_ptr_q;
  assign pkt_empty = (pkt_wr_ptr_q == pkt_rd_ptr_q);
  assign pkt_full  = (pkt_wr_ptr_q[PKT_AW] != pkt_rd_ptr_q[PKT_AW]) &&
                     (pkt_wr_ptr_q[PKT_AW-1:0] == pkt_rd_ptr_q[PKT_AW-1:0]);
  assign admit_ok  = (pkt_used <= ADMIT_MAX_USED);

  always_comb begin
    accepting_d = accepting_q;
    pkt_wr_en   = 1'b0;
    adm_drop    = 1'b0;
    if (i_pkt_valid) begin
      if (in_head) begin
        if (admit_ok) begin
          pkt_wr_en   = ~pkt_full;
          accepting_d = ~in_tail;
        end else begin
          adm_drop    = 1'b1;
          accepting_d = 1'b0;
        end
      end else if (accepting_q) begin
        pkt_wr_en = ~pkt_full;
        if (in_tail) accepting_d = 1'b0;
      end
    end
  end

  assign pkt_wr_ptr_d = pkt_wr_ptr_q + (PKT_AW+1)'(pkt_wr_en);

  // Block RAM with registered read; the read address is the next-state pointer so
  // the popped-to entry is already in pkt_rd_data_q on the following cycle.
  logic [133:0] pkt_mem [0:PKT_DEPTH-1];
  logic [133:0] pkt_rd_data_q;
  logic         pkt_stale_q, pkt_stale_d;
  logic         pkt_pop, pkt_avail;

  always_ff @(posedge i_clk) begin
    if (pkt_wr_en) pkt_mem[pkt_wr_ptr_q[PKT_AW-1:0]] <= i_pkt;
    pkt_rd_data_q <= pkt_mem[pkt_rd_ptr_d[PKT_AW-1:0]];
  end

  // A read colliding with a write to the same entry returns old data; flag it for one cycle.
  assign pkt_stale_d  = pkt_wr_en && (pkt_wr_ptr_q[PKT_AW-1:0] == pkt_rd_ptr_d[PKT_AW-1:0]);
  assign pkt_avail    = ~pkt_empty && ~pkt_stale_q;
  assign pkt_rd_ptr_d = pkt_rd_ptr_q + (PKT_AW+1)'(pkt_pop);

  // ---------------- metadata FIFO ----------------
  logic [META_AW:0]        meta_wr_ptr_q, meta_rd_ptr_q;
  logic [META_AW:0]        meta_wr_ptr_d, meta_rd_ptr_d;
  logic                    meta_empty, meta_full, meta_wr_en, meta_pop;
  logic                    meta_ovf_q, meta_ovf_d;
  logic [META_ENTRY_W-1:0] meta_mem [0:META_DEPTH-1];
  logic [META_ENTRY_W-1:0] meta_head;
  logic                    meta_unused;

  assign meta_unused = ^i_meta[META_W-2:48];
  assign meta_empty  = (meta_wr_ptr_q == meta_rd_ptr_q);
  assign meta_full   = (meta_wr_ptr_q[META_AW] != meta_rd_ptr_q[META_AW]) &&
                       (meta_wr_ptr_q[META_AW-1:0] == meta_rd_ptr_q[META_AW-1:0]);
  assign meta_wr_en  = i_meta_valid && ~meta_full;
  assign meta_ovf_d  = meta_ovf_q | (i_meta_valid & meta_full);
  assign meta_head   = meta_mem[meta_rd_ptr_q[META_AW-1:0]];
  assign meta_wr_ptr_d = meta_wr_ptr_q + (META_AW+1)'(meta_wr_en);
  assign meta_rd_ptr_d = meta_rd_ptr_q + (META_AW+1)'(meta_pop);

  always_ff @(posedge i_clk) begin
    if (meta_wr_en)
      meta_mem[meta_wr_ptr_q[META_AW-1:0]] <= {i_meta[META_W-1], i_meta[47:0]};
  end

  // ---------------- egress FSM ----------------
  function automatic logic [133:0] rewrite_head(input logic [133:0] beat,
                                                input logic [1:0]   mode,
                                                input logic [47:0]  new_dst);
    logic [133:0] r;
    r = beat;
    case (mode)
      2'b01: begin
        r[127:80] = beat[79:32];
        r[79:32]  = beat[127:80];
      end
      2'b10: begin
        r[127:80] = new_dst;
        r[79:32]  = beat[127:80];
      end
      default: ;
    endcase
    return r;
  endfunction

  state_t       state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [133:0] out_data_q, out_data_d;
  logic [31:0]  pkt_cnt_q, pkt_cnt_d;
  logic [31:0]  drop_cnt_q, drop_cnt_d;
  logic         out_xfer, pkt_done, fsm_drop;
  logic         rd_tail;

  assign out_xfer = out_valid_q && i_out_ready;
  assign rd_tail  = pkt_rd_data_q[133];

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pkt_pop     = 1'b0;
    meta_pop    = 1'b0;
    pkt_done    = 1'b0;
    fsm_drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (~meta_empty && ~pkt_empty) state_d = S_HEAD;
      end
      S_HEAD: begin
        if (pkt_avail) begin
          pkt_pop = 1'b1;
          if (meta_head[48]) begin
            // A dropped single-beat packet is already complete here.
            if (rd_tail) begin
              meta_pop = 1'b1;
              fsm_drop = 1'b1;
              state_d  = S_IDLE;
            end else begin
              state_d  = S_DROP;
            end
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = rewrite_head(pkt_rd_data_q, i_mode, meta_head[47:0]);
            state_d     = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (out_xfer && out_data_q[133]) begin
          out_valid_d = 1'b0;
          meta_pop    = 1'b1;
          pkt_done    = 1'b1;
          state_d     = S_IDLE;
        end else if (~out_valid_q || out_xfer) begin
          if (pkt_avail) begin
            pkt_pop     = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = pkt_rd_data_q;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      S_DROP: begin
        if (pkt_avail) begin
          pkt_pop = 1'b1;
          if (rd_tail) begin
            meta_pop = 1'b1;
            fsm_drop = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pkt_cnt_d  = pkt_cnt_q + 32'(pkt_done);
  assign drop_cnt_d = drop_cnt_q + 32'(adm_drop) + 32'(fsm_drop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pkt_wr_ptr_q  <= '0;
      pkt_rd_ptr_q  <= '0;
      pkt_stale_q   <= 1'b0;
      accepting_q   <= 1'b0;
      meta_wr_ptr_q <= '0;
      meta_rd_ptr_q <= '0;
      meta_ovf_q    <= 1'b0;
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      pkt_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pkt_wr_ptr_q  <= pkt_wr_ptr_d;
      pkt_rd_ptr_q  <= pkt_rd_ptr_d;
      pkt_stale_q   <= pkt_stale_d;
      accepting_q   <= accepting_d;
      meta_wr_ptr_q <= meta_wr_ptr_d;
      meta_rd_ptr_q <= meta_rd_ptr_d;
      meta_ovf_q    <= meta_ovf_d;
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      pkt_cnt_q     <= pkt_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign o_data_valid = out_valid_q;
  assign o_data       = out_data_q;
  assign o_pkt_cnt    = pkt_cnt_q;
  assign o_drop_cnt   = drop_cnt_q;
  assign o_meta_ovf   = meta_ovf_q;

endmodule

// File: tb/tb_hypipe_pkt_meta_merge.sv
// Directed bench for hypipe_pkt_meta_merge: hand-built packets and metadata,
// expected beats and counters written out by hand per scenario.
`timescale 1ns/1ps
module tb_hypipe_pkt_meta_merge;

  localparam logic [47:0] DST = 48'h001122334455;
  localparam logic [47:0] SRC = 48'h66778899AABB;

  logic         clk = 1'b0;
  logic         rst;
  logic         pkt_valid;
  logic [133:0] pkt;
  logic         meta_valid;
  logic [127:0] meta;
  logic [1:0]   mode;
  logic         out_ready;
  logic         o_data_valid;
  logic [133:0] o_data;
  logic [31:0]  o_pkt_cnt;
  logic [31:0]  o_drop_cnt;
  logic         o_meta_ovf;

  always #5 clk = ~clk;

  hypipe_pkt_meta_merge #(
    .PKT_AW(9), .META_AW(4), .META_W(128), .MAX_BEATS(96)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pkt_valid  (pkt_valid),
    .i_pkt        (pkt),
    .i_meta_valid (meta_valid),
    .i_meta       (meta),
    .i_mode       (mode),
    .i_out_ready  (out_ready),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .o_pkt_cnt    (o_pkt_cnt),
    .o_drop_cnt   (o_drop_cnt),
    .o_meta_ovf   (o_meta_ovf)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: samples 2ns before each rising edge.
  logic [133:0] out_q[$];
  int           out_cyc[$];
  logic [133:0] exp_q[$];
  int           valid_cycles = 0;
  logic         prev_hold = 1'b0;
  logic [133:0] prev_data = '0;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 134'(o_data_valid), 134'd1);
        check("hold_data", o_data, prev_data);
      end
      if (o_data_valid) valid_cycles++;
      if (o_data_valid && out_ready) begin
        out_q.push_back(o_data);
        out_cyc.push_back(cyc);
      end
      prev_hold = o_data_valid && !out_ready;
      prev_data = o_data;
    end
  end

  function automatic logic [133:0] mk_beat(input int id, input int idx, input int n,
                                           input logic [47:0] dst, input logic [47:0] src);
    logic [1:0] tag;
    tag = (n == 1) ? 2'b11 : (idx == 0) ? 2'b01 : (idx == n - 1) ? 2'b10 : 2'b00;
    if (idx == 0) return {tag, 4'hF, dst, src, 32'(id)};
    return {tag, 4'(idx), 32'(id), 32'(idx), 64'hA5A5_0000_0000_0000 + 64'(idx)};
  endfunction

  task automatic send_pkt(input int id, input int n, input int meta_at,
                          input logic drop, input logic [47:0] mac, output int meta_cyc);
    int last;
    last = (meta_at > n - 1) ? meta_at : n - 1;
    meta_cyc = -1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      pkt_valid  = (c < n);
      pkt        = (c < n) ? mk_beat(id, c, n, DST, SRC) : '0;
      meta_valid = (c == meta_at);
      meta       = {drop, 79'd0, mac};
      if (c == meta_at) meta_cyc = cyc + 1;
    end
    @(negedge clk);
    pkt_valid  = 1'b0;
    meta_valid = 1'b0;
  endtask

  task automatic send_metas(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      meta_valid = 1'b1;
      meta       = {1'b0, 79'd0, 48'h0};
    end
    @(negedge clk);
    meta_valid = 1'b0;
  endtask

  task automatic expect_pass(input int id, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(id, i, n, DST, SRC));
  endtask

  task automatic wait_and_compare(input string tag, input int budget, output int first_cyc);
    int n;
    for (int i = 0; i < budget && out_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({tag, "_xfers"}, 134'(out_q.size()), 134'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
    first_cyc = (out_cyc.size() > 0) ? out_cyc[0] : -1;
    out_q.delete();
    out_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mc, fc, v0;
    rst = 1'b1; pkt_valid = 1'b0; pkt = '0; meta_valid = 1'b0; meta = '0;
    mode = 2'b00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 134'(o_data_valid), 134'd0);
    check("rst_data", o_data, 134'd0);
    check("rst_pkt_cnt", 134'(o_pkt_cnt), 134'd0);
    check("rst_drop_cnt", 134'(o_drop_cnt), 134'd0);
    check("rst_ovf", 134'(o_meta_ovf), 134'd0);
    rst = 1'b0;

    // Stray body and tail beats before any head must be ignored.
    @(negedge clk); pkt_valid = 1'b1; pkt = mk_beat(99, 1, 3, DST, SRC);
    @(negedge clk); pkt = mk_beat(99, 2, 3, DST, SRC);
    @(negedge clk); pkt_valid = 1'b0;

    // 4-beat packet, swap MACs, meta 3 cycles after the head.
    mode = 2'b01;
    exp_q.push_back({2'b01, 4'hF, 48'h66778899AABB, 48'h001122334455, 32'd1});
    for (int i = 1; i < 4; i++) exp_q.push_back(mk_beat(1, i, 4, DST, SRC));
    send_pkt(1, 4, 3, 1'b0, 48'h0, mc);
    wait_and_compare("t1", 60, fc);
    check("t1_latency", 134'(fc), 134'(mc + 2));
    check("t1_pkt_cnt", 134'(o_pkt_cnt), 134'd1);

    // Same packet, dst from metadata, src from old dst.
    mode = 2'b10;
    exp_q.push_back({2'b01, 4'hF, 48'hDEADBEEF0001, 48'h001122334455, 32'd2});
    for (int i = 1; i < 4; i++) exp_q.push_back(mk_beat(2, i, 4, DST, SRC));
    send_pkt(2, 4, 3, 1'b0, 48'hDEADBEEF0001, mc);
    wait_and_compare("t2", 60, fc);
    check("t2_pkt_cnt", 134'(o_pkt_cnt), 134'd2);

    // Single-beat packet dropped by metadata, then a normal 2-beat packet.
    mode = 2'b00;
    v0 = valid_cycles;
    send_pkt(3, 1, 0, 1'b1, 48'h0, mc);
    wait_and_compare("t3_drop", 10, fc);
    check("t3_no_valid", 134'(valid_cycles - v0), 134'd0);
    check("t3_drop_cnt", 134'(o_drop_cnt), 134'd1);
    expect_pass(4, 2);
    send_pkt(4, 2, 0, 1'b0, 48'h0, mc);
    wait_and_compare("t3_next", 60, fc);
    check("t3_pkt_cnt", 134'(o_pkt_cnt), 134'd3);

    // 6-beat packet with ready toggled 1,0,0,1.
    expect_pass(5, 6);
    send_pkt(5, 6, -1, 1'b0, 48'h0, mc);
    send_metas(1);
    for (int i = 0; i < 20 && !o_data_valid; i++) @(negedge clk);
    @(negedge clk); out_ready = 1'b0;
    @(negedge clk); out_ready = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    wait_and_compare("t4", 60, fc);
    check("t4_pkt_cnt", 134'(o_pkt_cnt), 134'd4);

    // Fill packet FIFO to 500 entries, then a head that must be refused.
    for (int k = 0; k < 5; k++) begin
      expect_pass(10 + k, 100);
      send_pkt(10 + k, 100, -1, 1'b0, 48'h0, mc);
    end
    send_pkt(15, 3, -1, 1'b0, 48'h0, mc);
    check("t5_drop_cnt", 134'(o_drop_cnt), 134'd2);
    check("t5_idle_valid", 134'(o_data_valid), 134'd0);
    send_metas(5);
    wait_and_compare("t5", 1500, fc);
    check("t5_pkt_cnt", 134'(o_pkt_cnt), 134'd9);

    // Metadata overflow: 16 fit, the 17th is lost.
    send_metas(16);
    check("t6_ovf_16", 134'(o_meta_ovf), 134'd0);
    send_metas(1);
    check("t6_ovf_17", 134'(o_meta_ovf), 134'd1);

    // Reset while a packet is stalled in SEND.
    out_ready = 1'b0;
    send_pkt(20, 20, -1, 1'b0, 48'h0, mc);
    check("t7_mid_send_valid", 134'(o_data_valid), 134'd1);
    rst = 1'b1;
    #1;
    check("t7_rst_valid", 134'(o_data_valid), 134'd0);
    check("t7_rst_pkt_cnt", 134'(o_pkt_cnt), 134'd0);
    check("t7_rst_drop_cnt", 134'(o_drop_cnt), 134'd0);
    check("t7_rst_ovf", 134'(o_meta_ovf), 134'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    wait_and_compare("t7_flush", 5, fc);
    mode = 2'b01;
    exp_q.push_back({2'b01, 4'hF, SRC, DST, 32'd21});
    for (int i = 1; i < 3; i++) exp_q.push_back(mk_beat(21, i, 3, DST, SRC));
    send_pkt(21, 3, 1, 1'b0, 48'h0, mc);
    wait_and_compare("t7", 60, fc);
    check("t7_pkt_cnt", 134'(o_pkt_cnt), 134'd1);
    check("t7_drop_cnt", 134'(o_drop_cnt), 134'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hypipe_pkt_meta_merge.md
Name: hypipe_pkt_meta_merge

Overview:
- Joins the raw 134b packet stream with per-packet metadata emitted by the parser/deparser after a variable latency.
- Buffers packets in a parametrised FIFO and metadata in a second FIFO.
- On metadata availability, streams the matching packet out with an optional Ethernet MAC rewrite on the head beat, or discards it.
- Sits at the tail of the hybrid pipeline, replacing the fixed MAC-swap stage; adds output backpressure, drop control and statistics.

Parameters:
- PKT_AW, 9, log2 of packet FIFO depth (512 beats).
- META_AW, 4, log2 of metadata FIFO depth (16 entries).
- META_W, 128, metadata width.
- MAX_BEATS, 96, largest packet in beats; admission threshold.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_pkt_valid  in  1  packet beat valid, no backpressure
- i_pkt  in  134  [133:132] tag (01 head, 10 tail, 11 single-beat, 00 body), [131:128] valid, [127:0] data
- i_meta_valid  in  1  metadata entry valid, one per admitted packet
- i_meta  in  META_W  [META_W-1] drop flag, [47:0] new dst MAC, others ignored
- i_mode  in  2  00 pass, 01 swap dst/src MAC, 10 dst<=meta[47:0] and src<=old dst, 11 pass
- i_out_ready  in  1  downstream ready
- o_data_valid  out  1  output beat valid
- o_data  out  134  output beat
- o_pkt_cnt  out  32  packets fully transmitted, wrapping
- o_drop_cnt  out  32  packets discarded (admission or meta flag), wrapping
- o_meta_ovf  out  1  sticky: metadata written while meta FIFO full

Behaviour:
- Reset: i_rst is asynchronous and active-high.
  - All outputs reset to 0; FIFO pointers are cleared and the FSM goes to IDLE.
  - Reset mid-packet discards all buffered data. The next accepted beat must be a head.
- Admission, evaluated on each head beat (tag 01 or 11):
  - Head is accepted if free entries in the packet FIFO are >= MAX_BEATS.
  - Otherwise the whole packet (head through tail) is not written and o_drop_cnt increments once.
  - Beats arriving before the first head after reset are ignored.
- Meta FIFO:
  - Written on i_meta_valid if not full.
  - If full, the entry is lost and o_meta_ovf sets; only reset clears it.
  - Upstream guarantees exactly one meta per admitted packet.
- FSM states:
  - IDLE: when the meta FIFO and packet FIFO are both non-empty, go to HEAD.
  - HEAD: capture meta and i_mode, pop and present the head beat. If the drop flag is set, go to DROP; otherwise go to SEND.
  - SEND: each beat is transferred only on o_data_valid & i_out_ready.
    - o_data is held stable while valid and not ready.
    - On transfer of the tail beat (tag 10 or 11): pop meta, increment o_pkt_cnt, go to IDLE.
  - DROP: pop one beat per cycle with o_data_valid=0, waiting on the FIFO when empty. At the tail: pop meta, increment o_drop_cnt, go to IDLE.
- Packet FIFO underflow mid-packet: o_data_valid deasserts until the next beat is present. No bubble beats are emitted.
- Rewrite on the head beat only. dst MAC = data[127:80], src MAC = data[79:32].
  - Mode 01: output dst=old src, src=old dst.
  - Mode 10: output dst=meta[47:0], src=old dst.
  - Mode 00/11: unchanged.
  - Tag and valid field bits always pass unchanged.
- Latency and throughput:
  - First output beat is valid 2 cycles after the later of the head write and the meta write, with FIFOs otherwise empty.
  - Sustained throughput is 1 beat/cycle when i_out_ready=1.
  - Back-to-back packets insert 1 IDLE cycle between a tail and the next head.
- Simultaneous events:
  - FIFO write and read in the same cycle are both performed; the count is unchanged.
  - Full and empty are computed from registered pointers with an extra wrap bit.
- Counters wrap from 0xFFFFFFFF to 0.

Test Plan:
- 4-beat packet (dst 00:11:22:33:44:55, src 66:77:88:99:AA:BB) with meta drop=0, mode=01 sent 3 cycles later, ready=1 -> 4 beats out; head data[127:32]=66778899AABB_001122334455; o_pkt_cnt=1.
- Same packet with mode=10, meta[47:0]=0xDEADBEEF0001 -> head dst=DEADBEEF0001, src=001122334455; body beats bit-identical to input.
- Single-beat packet (tag 11) with meta drop=1 -> no o_data_valid; o_drop_cnt=1; the next packet follows normally.
- Toggle i_out_ready 1,0,0,1 during a 6-beat packet -> o_data held over the stalls, no beat lost or duplicated, 6 transfers total.
- Fill the packet FIFO to 500 used entries, then send a head -> packet discarded, o_drop_cnt+1, FIFO contents unchanged; 17 metas with no reads -> o_meta_ovf=1.
- Assert i_rst mid-SEND for 1 cycle -> o_data_valid=0 immediately, counters 0, the subsequent packet plus meta is output correctly.
